uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver, 8 data bits, LSB first, 1 stop bit, optional even parity. It samples the `rx` line at mid-bit using a per-bit clock counter of `FACTOR` cycles, and presents each received byte on a valid/ready output port. It is the receive end of the team's UART link, paired with the transmitter that shares the same `FACTOR` bit period.

## Interface
- `FACTOR`, 16: clock cycles per bit; legal range 4..256.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line; idle high; asynchronous to `clk`.
- `data`  out  8  received byte; valid while `valid`=1.
- `valid`  out  1  byte available; held until accepted.
- `ready`  in  1  consumer accepts `data` when `valid`&&`ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte completed while previous byte unaccepted.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (constant 0 without `UART_RX_PARITY_EN`).

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: on `rx_s`=0, clear the bit counter and go to START.
- START: after FACTOR/2 cycles (integer division), sample `rx_s`. If 0, clear the counter and go to DATA. If 1, treat it as a glitch and return to IDLE with no flags.
- DATA: sample every FACTOR cycles into shift register, LSB first. After bit 7, go to PARITY or STOP.
- PARITY: sample one bit after FACTOR cycles. Mismatch means the XOR of 8 data bits and the parity bit is 1.
- STOP: sample after FACTOR cycles.
  - Stop=1, no parity error: deliver the byte, go to IDLE.
  - Stop=0: pulse `frame_err`, discard the byte, go to BREAK.
  - Parity error with stop=1: pulse `parity_err`, discard the byte, go to IDLE.
- BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Delivery:
  - If `valid`=0, or `valid`&&`ready` in the same cycle: load `data` and hold `valid`=1.
  - If `valid`&&!`ready`: pulse `overrun`; the new byte is dropped and the old `data`/`valid` are kept.
- Handshake: `valid` falls the cycle after `valid`&&`ready` unless a new byte loads in that same cycle. `data` never changes while `valid`=1 and `ready`=0.
- Reset mid-frame: asynchronously returns to IDLE. All outputs are cleared and the partial byte is lost.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `overrun`=0, `parity_err`=0; state IDLE; synchronizer flops =1.
- Latency: a pin edge at cycle e appears on `rx_s` at e+2.
- Sample schedule, with t0 = first cycle `rx_s`=0 in IDLE:
  - start check at t0+FACTOR/2;
  - data bit i at t0+FACTOR/2+(i+1)·FACTOR;
  - stop bit at t0+FACTOR/2+9·FACTOR (+10·FACTOR with parity).
- `valid` and the error pulses rise the cycle after the stop sample.
- The receiver is back in IDLE the cycle after the stop sample. A start edge arriving immediately after is detected, allowing back-to-back frames with zero idle gap.
- Counter: 8 bits, counts 0..FACTOR-1, wraps to 0 at each sample point.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, the even parity bit is expected between bit 7 and stop, and `parity_err` is live. Frame length is 11 bits.
- `UART_RX_PARITY_EN` undefined: no PARITY state, `parity_err` is tied 0, frame length is 10 bits. Port list is identical in both cases.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding constants;
  - `UART_DATA_BITS`=8;
  - the FACTOR legality check (4..256), also used by the transmitter.
- Sub-module `uart_sync2`: 2-flop synchronizer with async active-low reset to 1. The bit counter and FSM stay inline.

## Test plan
- FACTOR=16, send 0xA5 with stop=1, `ready`=1 → `data`=0xA5, `valid` for 1 cycle, rising exactly t0+8+9·16+1 cycles after t0; no error pulses.
- `rx` low pulse of 5 cycles in IDLE → stays idle; no `valid`, no flags.
- Send 0x3C with stop=0, then hold `rx` low for 40 bit times, then 0x81 normal → `frame_err` pulse once, no `valid` for 0x3C; 0x81 is then received correctly.
- `ready`=0, send 0x11 then 0x22 back-to-back → `data`=0x11 held, `overrun` pulse on 0x22 completion; raising `ready` then drops `valid`.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `parity_err` pulse, no `valid`. Send 0x07 with parity bit 1 → `data`=0x07.
- Assert `reset` at bit 4 of a frame, release, send 0x5A → all outputs 0 during reset; `data`=0x5A afterwards with no stale bits.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: state encoding, data width, FACTOR legality
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FACTOR_MIN = 4;
    localparam int UART_FACTOR_MAX = 256;

    // Receiver FSM encoding; the parity state only exists when parity is built in
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    // Bit period must be long enough for a mid-bit sample and fit the 8-bit counter
    function automatic bit uart_factor_ok(input int factor);
        return (factor >= UART_FACTOR_MIN) && (factor <= UART_FACTOR_MAX);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer, resets to 1 (idle line level)
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q;
    logic s2_d, s2_q;

    // Next values simply shift the asynchronous input down the chain
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Both stages reset high so a reset never looks like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready output; UART_RX_PARITY_EN adds even parity
module uart_rx
    import uart_pkg::*;
#(
    parameter int FACTOR = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    generate
        if (!uart_factor_ok(FACTOR)) begin : g_bad_factor
            $error("uart_rx: FACTOR must be in 4..256");
        end
    endgenerate

    // Counter compare points: mid start bit, then one full bit period per sample
    localparam logic [7:0] CNT_HALF = 8'(FACTOR / 2 - 1);
    localparam logic [7:0] CNT_LAST = 8'(FACTOR - 1);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    uart_state_e               state_d, state_q;
    logic [7:0]                cnt_d, cnt_q;
    logic [2:0]                bit_d, bit_q;
    logic [UART_DATA_BITS-1:0] shift_d, shift_q;
    logic [7:0]                data_d, data_q;
    logic                      valid_d, valid_q;
    logic                      fe_d, fe_q;
    logic                      ov_d, ov_q;
    logic                      par_bad;
`ifdef UART_RX_PARITY_EN
    logic                      par_d, par_q;
    logic                      pe_d, pe_q;

    // Even parity: data bits plus parity bit must XOR to zero
    assign par_bad = ^{shift_q, par_q};
`else
    assign par_bad = 1'b0;
`endif

    // Frame sequencing, bit sampling and output handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        pe_d    = 1'b0;
`endif

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                bit_d = 3'd0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = 8'd0;
                    // A start bit that is high again at mid-bit was only a glitch
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 8'd0;
                    if (!rx_s) begin
                        fe_d    = 1'b1;
                        state_d = ST_BREAK;
                    end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                        pe_d    = 1'b1;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                        // Load only when the slot is free or being freed this cycle
                        if (!valid_q || ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = 8'd0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // All receiver state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
            shift_q <= '0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            pe_q    <= pe_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized frames checked against a frame-level model
module tb_uart_rx;

    localparam int F = 16;
    localparam int H = F / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // Pin edge -> rx_s takes 2 cycles, then mid start, data, [parity], stop, then +1
    localparam int LAT = 3 + H + (9 + NPAR) * F;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    uart_rx #(.FACTOR(F)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: just after each falling edge, inputs and outputs are both stable
    logic [7:0] got_q[$];
    int n_fe = 0, n_ov = 0, n_pe = 0, n_vcyc = 0, hold_viol = 0, rise_cyc = 0;
    logic       valid_prev = 1'b0, ready_prev = 1'b0;
    logic [7:0] data_prev = 8'd0;

    always @(negedge clk) begin
        #1;
        if (reset) begin
            if (valid) n_vcyc++;
            if (valid && !valid_prev) rise_cyc = cyc;
            if (valid && valid_prev && !ready_prev && (data !== data_prev)) hold_viol++;
            if (valid && ready) got_q.push_back(data);
            if (frame_err) n_fe++;
            if (overrun) n_ov++;
            if (parity_err) n_pe++;
        end
        valid_prev = valid;
        ready_prev = ready;
        data_prev  = data;
    end

    int b_fe, b_ov, b_pe, b_vcyc, b_got;
    int start_cyc;

    task automatic snap();
        b_fe   = n_fe;
        b_ov   = n_ov;
        b_pe   = n_pe;
        b_vcyc = n_vcyc;
        b_got  = got_q.size();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Drives one full frame starting at a falling edge; leaves rx at the stop level
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_good);
        start_cyc = cyc;
        hold(1'b0, F);
        for (int i = 0; i < 8; i++) hold(b[i], F);
        if (NPAR == 1) hold((^b) ^ ~par_good, F);
        hold(stop, F);
    endtask

    logic [7:0] exp_q[$];
    int         exp_fe, exp_pe;
    logic [7:0] rb;
    logic       rstop, rpg;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Single good frame: data, exact latency, one-cycle valid
        ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1, 1'b1);
        hold(1'b1, 3 * F);
        check("a5_count", 32'(got_q.size() - b_got), 32'd1);
        check("a5_data", 32'(got_q[b_got]), 32'hA5);
        check("a5_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
        check("a5_valid_cycles", 32'(n_vcyc - b_vcyc), 32'd1);
        check("a5_flags", 32'((n_fe - b_fe) + (n_ov - b_ov) + (n_pe - b_pe)), 32'd0);

        // Short low glitch is rejected at the mid start sample
        snap();
        hold(1'b0, 5);
        hold(1'b1, 3 * F);
        check("glitch_valid", 32'(n_vcyc - b_vcyc), 32'd0);
        check("glitch_flags", 32'((n_fe - b_fe) + (n_ov - b_ov) + (n_pe - b_pe)), 32'd0);

        // Framing error, long break, then a clean frame
        snap();
        send_frame(8'h3C, 1'b0, 1'b1);
        hold(1'b0, 40 * F);
        hold(1'b1, 2 * F);
        send_frame(8'h81, 1'b1, 1'b1);
        hold(1'b1, 3 * F);
        check("fe_pulses", 32'(n_fe - b_fe), 32'd1);
        check("fe_count", 32'(got_q.size() - b_got), 32'd1);
        check("fe_next_data", 32'(got_q[b_got]), 32'h81);

        // Overrun: second byte dropped while the first is held
        ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        hold(1'b1, 3 * F);
        check("ov_valid_held", 32'(valid), 32'h1);
        check("ov_data_held", 32'(data), 32'h11);
        check("ov_pulses", 32'(n_ov - b_ov), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ov_valid_drop", 32'(valid), 32'h0);
        check("ov_accepted", 32'(got_q.size() - b_got), 32'd1);
        check("ov_accepted_data", 32'(got_q[b_got]), 32'h11);

`ifdef UART_RX_PARITY_EN
        // Parity: wrong bit is flagged and discarded, right bit delivers
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        hold(1'b1, 3 * F);
        check("par_bad_pulse", 32'(n_pe - b_pe), 32'd1);
        check("par_bad_valid", 32'(n_vcyc - b_vcyc), 32'd0);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        hold(1'b1, 3 * F);
        check("par_good_pulse", 32'(n_pe - b_pe), 32'd0);
        check("par_good_data", 32'(got_q[b_got]), 32'h07);
`endif

        // Reset in the middle of a frame while a byte is pending
        ready = 1'b0;
        send_frame(8'hC3, 1'b1, 1'b1);
        hold(1'b1, 2 * F);
        check("pre_rst_valid", 32'(valid), 32'h1);
        hold(1'b0, F);
        for (int i = 0; i < 4; i++) hold(i[0], F);
        hold(1'b1, H);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_flags", 32'({frame_err, overrun, parity_err}), 32'h0);
        reset = 1'b1;
        ready = 1'b1;
        hold(1'b1, 2 * F);
        snap();
        send_frame(8'h5A, 1'b1, 1'b1);
        hold(1'b1, 3 * F);
        check("postrst_count", 32'(got_q.size() - b_got), 32'd1);
        check("postrst_data", 32'(got_q[b_got]), 32'h5A);
        check("postrst_flags", 32'((n_fe - b_fe) + (n_ov - b_ov) + (n_pe - b_pe)), 32'd0);

        // Random frames, mostly back-to-back, with occasional bad stop/parity
        snap();
        exp_fe = 0;
        exp_pe = 0;
        for (int k = 0; k < 24; k++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rpg   = ($urandom_range(0, 3) != 0);
            if (!rstop) exp_fe++;
            else if (NPAR == 1 && !rpg) exp_pe++;
            else exp_q.push_back(rb);
            send_frame(rb, rstop, rpg);
            if (!rstop) hold(1'b1, 2 * F);
            else if ($urandom_range(0, 1) == 1) hold(1'b1, $urandom_range(1, 3 * F));
        end
        hold(1'b1, 3 * F);
        check("rnd_count", 32'(got_q.size() - b_got), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("rnd_data_%0d", k), 32'(got_q[b_got + k]), 32'(exp_q[k]));
        check("rnd_fe", 32'(n_fe - b_fe), 32'(exp_fe));
        check("rnd_pe", 32'(n_pe - b_pe), 32'(exp_pe));
        check("rnd_ov", 32'(n_ov - b_ov), 32'd0);

        check("hold_stable", 32'(hold_viol), 32'd0);
`ifndef UART_RX_PARITY_EN
        check("parity_err_never", 32'(n_pe), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
